// File: rtl/vec_pkg.sv
// Shared fixed-point vector constants and the magnitude FSM state encoding.
// Combinational only; no handshake of its own.
package vec_pkg;
    localparam int VEC_W    = 24;
    localparam int VEC_FRAC = 12;
    localparam int VEC_INT  = VEC_W - 1 - VEC_FRAC;
    localparam logic [VEC_W-1:0] VEC_ONE = VEC_W'(1) << VEC_FRAC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQ   = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } mag_state_t;
endpackage

// File: rtl/vec_magnitude_if.sv
// Input vector and output magnitude handshakes for vec_magnitude.
// Valid/ready on both sides; the master drives vectors and consumes results.
interface vec_magnitude_if
    import vec_pkg::*;
#(
    parameter int W = VEC_W
);
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] x;
    logic signed [W-1:0] y;
    logic signed [W-1:0] z;
    logic                out_valid;
    logic                out_ready;
    logic [W-1:0]        mag;

    modport master (
        output in_valid, x, y, z, out_ready,
        input  in_ready, out_valid, mag
    );

    modport slave (
        input  in_valid, x, y, z, out_ready,
        output in_ready, out_valid, mag
    );
endinterface

// File: rtl/isqrt_step.sv
// One restoring square-root step: consumes two radicand bits, yields one root bit.
// Purely combinational, no handshake.
module isqrt_step
    import vec_pkg::*;
#(
    parameter int W = VEC_W
) (
    input  logic [W-1:0] rem,
    input  logic [W-1:0] root,
    input  logic [1:0]   bits,
    output logic [W-1:0] rem_nxt,
    output logic [W-1:0] root_nxt
);
    logic [W+1:0] r;
    logic [W+1:0] t;
    logic         ge;

    assign r  = {rem, bits};
    assign t  = {root, 2'b01};
    assign ge = (r >= t);

    // Only the low W bits of the remainder are ever live before the final step.
    assign rem_nxt  = ge ? (r[W-1:0] - t[W-1:0]) : r[W-1:0];
    assign root_nxt = {root[W-2:0], ge};
endmodule

// File: rtl/vec_magnitude.sv
// floor(sqrt(x^2+y^2+z^2)) of a signed fixed-point 3-vector, one root bit per clock.
// W+2 cycles per vector; one vector in flight, result held in DONE until out_ready.
module vec_magnitude
    import vec_pkg::*;
#(
    parameter int W = VEC_W
) (
    input  logic     clk,
    input  logic     rst,
    vec_magnitude_if.slave bus
);
    localparam int CNT_W = $clog2(W);

    mag_state_t          state;
    mag_state_t          state_nxt;
    logic signed [W-1:0] xr;
    logic signed [W-1:0] yr;
    logic signed [W-1:0] zr;
    logic [2*W-1:0]      rad;
    logic [W-1:0]        rem;
    logic [W-1:0]        root;
    logic [W-1:0]        rem_nxt;
    logic [W-1:0]        root_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [W-1:0]        mag_q;
    logic                out_valid_q;
    logic                accept;
    logic                last;

    logic signed [2*W-1:0] xe;
    logic signed [2*W-1:0] ye;
    logic signed [2*W-1:0] ze;
    logic [2*W-1:0]        sum_sq;

    // Sign-extending first lets -2^(W-1) square to +2^(2W-2) without an abs step.
    assign xe     = {{W{xr[W-1]}}, xr};
    assign ye     = {{W{yr[W-1]}}, yr};
    assign ze     = {{W{zr[W-1]}}, zr};
    assign sum_sq = $unsigned(xe * xe) + $unsigned(ye * ye) + $unsigned(ze * ze);

    assign bus.in_ready  = !rst && ((state == IDLE) || (state == DONE && bus.out_ready));
    assign bus.out_valid = out_valid_q;
    assign bus.mag       = mag_q;
    assign accept        = bus.in_valid && bus.in_ready;
    assign last          = (state == ITER) && (cnt == CNT_W'(W - 1));

    isqrt_step #(.W(W)) u_step (
        .rem      (rem),
        .root     (root),
        .bits     (rad[2*W-1 -: 2]),
        .rem_nxt  (rem_nxt),
        .root_nxt (root_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = SQ;
            SQ:   state_nxt = ITER;
            ITER: if (last) state_nxt = DONE;
            DONE: begin
                if (accept)             state_nxt = SQ;
                else if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xr          <= '0;
            yr          <= '0;
            zr          <= '0;
            rad         <= '0;
            rem         <= '0;
            root        <= '0;
            cnt         <= '0;
            mag_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                xr <= bus.x;
                yr <= bus.y;
                zr <= bus.z;
            end
            case (state)
                SQ: begin
                    rad  <= sum_sq;
                    rem  <= '0;
                    root <= '0;
                    cnt  <= '0;
                end
                ITER: begin
                    rem  <= rem_nxt;
                    root <= root_nxt;
                    rad  <= rad << 2;
                    cnt  <= cnt + CNT_W'(1);
                    if (last) begin
                        mag_q       <= root_nxt;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: if (bus.out_ready) out_valid_q <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_vec_magnitude.sv
// Directed table, backpressure/reset sequences and random vectors for vec_magnitude.
module tb_vec_magnitude;
    import vec_pkg::*;
    localparam int W   = VEC_W;
    localparam int LAT = W + 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vec_magnitude_if #(.W(W)) vi ();
    vec_magnitude #(.W(W)) dut (.clk(clk), .rst(rst), .bus(vi.slave));

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string  name;
        longint x;
        longint y;
        longint z;
        longint exp;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Golden model: integer floor square root of the exact sum of squares.
    function automatic longint ref_mag(input longint a, input longint b, input longint c);
        longint s;
        longint r;
        s = a * a + b * b + c * c;
        r = longint'($sqrt(real'(s)));
        while (r > 0 && r * r > s) r--;
        while ((r + 1) * (r + 1) <= s) r++;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns with the accepting edge just passed.
    task automatic send(input longint a, input longint b, input longint c);
        int n = 0;
        while (!vi.in_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("in_ready_timeout", 0, 1);
        vi.in_valid = 1'b1;
        vi.x = W'(a);
        vi.y = W'(b);
        vi.z = W'(c);
        tick();
        vi.in_valid = 1'b0;
    endtask

    // Counts edges with the accepting edge as edge 1.
    task automatic wait_result(output int lat);
        lat = 1;
        while (!vi.out_valid && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_vec(input string name, input longint a, input longint b,
                           input longint c, input longint exp);
        int lat;
        send(a, b, c);
        wait_result(lat);
        check({name, "_lat"}, lat, LAT);
        check(name, longint'(vi.mag), exp);
        tick();
    endtask

    vec_t tbl[6];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int            lat;
        longint        m0;
        logic          seen;
        logic [31:0]   tmp;
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        logic signed [W-1:0] sc;

        tbl[0] = '{"mag_345",     3 * VEC_ONE, 4 * VEC_ONE, 0, 20480};
        tbl[1] = '{"mag_unit",    4096, 4096, 4096, 7094};
        tbl[2] = '{"mag_unit_neg", -4096, -4096, -4096, 7094};
        tbl[3] = '{"mag_most_neg", -8388608, -8388608, -8388608, 14529495};
        tbl[4] = '{"mag_zero",    0, 0, 0, 0};
        tbl[5] = '{"mag_most_pos", 8388607, 0, 0, 8388607};

        rst = 1'b1;
        vi.in_valid  = 1'b0;
        vi.out_ready = 1'b1;
        vi.x = '0;
        vi.y = '0;
        vi.z = '0;
        tick();
        tick();
        check("rst_in_ready",  longint'(vi.in_ready), 0);
        check("rst_out_valid", longint'(vi.out_valid), 0);
        check("rst_mag",       longint'(vi.mag), 0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", longint'(vi.in_ready), 1);

        for (int i = 0; i < 6; i++)
            run_vec(tbl[i].name, tbl[i].x, tbl[i].y, tbl[i].z, tbl[i].exp);

        // Backpressure, then output and input handshakes on the same edge.
        vi.out_ready = 1'b0;
        send(12288, 16384, 0);
        wait_result(lat);
        check("bp_lat", lat, LAT);
        m0 = longint'(vi.mag);
        check("bp_mag", m0, 20480);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_valid", longint'(vi.out_valid), 1);
            check("bp_hold_mag", longint'(vi.mag), m0);
            check("bp_hold_in_ready", longint'(vi.in_ready), 0);
        end
        vi.out_ready = 1'b1;
        vi.in_valid  = 1'b1;
        vi.x = 24'sd4096;
        vi.y = 24'sd4096;
        vi.z = 24'sd4096;
        #1;
        check("b2b_in_ready", longint'(vi.in_ready), 1);
        tick();
        vi.in_valid = 1'b0;
        check("b2b_out_valid_drop", longint'(vi.out_valid), 0);
        wait_result(lat);
        check("b2b_lat", lat, LAT);
        check("b2b_mag", longint'(vi.mag), 7094);
        tick();

        // Reset while cnt==10 in ITER aborts the vector.
        send(8388607, -8388608, 12345);
        for (int i = 0; i < 11; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("abort_in_ready", longint'(vi.in_ready), 1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            seen = seen | vi.out_valid;
            tick();
        end
        check("abort_no_result", longint'(seen), 0);
        run_vec("after_abort", 12288, 16384, 0, 20480);

        for (int i = 0; i < 2000; i++) begin
            tmp = $urandom; sa = tmp[W-1:0];
            tmp = $urandom; sb = tmp[W-1:0];
            tmp = $urandom; sc = tmp[W-1:0];
            if ($urandom_range(0, 15) == 0) sa = {1'b1, {(W-1){1'b0}}};
            if ($urandom_range(0, 15) == 0) sc = '0;
            run_vec("rand", longint'(sa), longint'(sb), longint'(sc),
                    ref_mag(longint'(sa), longint'(sb), longint'(sc)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
